fetch_queue: RTL
================

// Module: fetch_queue
// PURPOSE
//  Parametrised prefetching fetch stage: streams sequential PCs into a pipelined instruction ROM
//  with fixed read latency, and buffers returned instructions with their PCs in a DEPTH-entry FIFO.
//  Decode consumes entries via a valid/ready handshake.
//  Branch/jump redirect squashes buffered and in-flight fetches, then restarts from a new PC.
// PARAMETERS
//  ADDR_W       32  PC / ROM address width (bits)
//  INSTR_W      32  instruction width (bits)
//  ROM_LATENCY  1   cycles from rom_en/rom_addr to valid rom_data (>=1)
//  DEPTH        4   FIFO entries (power of two, >=2); full throughput needs DEPTH >= ROM_LATENCY+2
//  PC_STEP      4   PC increment per instruction
// PORTS
//  clk          in   1        clock, all state on posedge
//  rstn         in   1        synchronous active-low reset
//  redirect     in   1        flush and restart fetch at redirect_pc
//  redirect_pc  in   ADDR_W   restart PC, sampled when redirect=1
//  rom_en       out  1        ROM read issue this cycle
//  rom_addr     out  ADDR_W   ROM read address (= fetch_pc, combinational)
//  rom_data     in   INSTR_W  ROM data, valid ROM_LATENCY cycles after the matching issue
//  out_valid    out  1        FIFO head valid
//  out_ready    in   1        decode accepts head
//  out_pc       out  ADDR_W   PC of head instruction
//  out_instr    out  INSTR_W  head instruction
// BEHAVIOUR
//  - Reset (rstn=0 at posedge): fetch_pc=0, FIFO empty, in-flight pipe cleared.
//    rom_en=0, out_valid=0, out_pc=0, out_instr=0; redirect ignored while in reset.
//  - State: fetch_pc reg; in-flight shift pipe of ROM_LATENCY stages {valid, pc}.
//    FIFO has rd/wr pointers of log2(DEPTH)+1 bits; count = wr-rd.
//  - Issue: rom_en = !redirect && (count + inflight_cnt < DEPTH), using registered values (no pop bypass).
//    On issue: stage0 <= {1, fetch_pc}; fetch_pc <= fetch_pc + PC_STEP (wraps mod 2^ADDR_W).
//  - Return: when last pipe stage is valid, {pc, rom_data} is written to FIFO at that edge.
//    Credit rule guarantees no overflow; an assertion checks write-when-full never occurs.
//  - Output: out_valid = count!=0; out_pc/out_instr driven from head entry (registered storage).
//    Pop when out_valid && out_ready. Simultaneous push and pop: count unchanged, both applied.
//  - Latency: issue in cycle t -> FIFO write at end of cycle t+ROM_LATENCY -> out_valid in t+ROM_LATENCY+1.
//    Example: cycle 0 = first cycle with rstn=1; addr 0 issued in cycle 0; out_valid=1, out_pc=0 in cycle ROM_LATENCY+1.
//  - Redirect (cycle t): rom_en=0 in t; at edge: all pipe valids cleared, FIFO emptied (rd=wr).
//    fetch_pc <= redirect_pc. A head handshake completing in t counts as consumed; everything younger is dropped.
//    ROM data returning after the redirect for squashed issues is ignored.
//    First new issue in t+1; out_valid for redirect_pc in t+ROM_LATENCY+2.
//  - Back-to-back redirects: last one wins; each flushes.
//  - Stall (out_ready=0): FIFO fills; issue stops once count+inflight==DEPTH.
//    Head stays stable (out_pc/out_instr unchanged while out_valid && !out_ready).
//  - Reset mid-operation: same as power-on reset; in-flight returns discarded.
// TESTING
//  1 Reset/stream: ROM_LATENCY=1, DEPTH=4, out_ready=1, ROM[i]=0x1000+i -> out_valid from cycle 2,
//    out_pc=0,4,8,... one per cycle once full rate reached, out_instr=0x1000+pc/4.
//  2 Backpressure: out_ready=0 for 10 cycles after first valid -> rom_en drops after 4 outstanding.
//    Head holds pc=0; on release pcs 0,4,8,12,16 are delivered in order with no loss or duplicate.
//  3 Redirect: redirect=1, redirect_pc=0x200 while 3 entries are buffered and 1 is in flight ->
//    next cycle rom_addr=0x200, queue empty; first out_pc=0x200 at t+ROM_LATENCY+2.
//    No stale pc appears at the output.
//  4 Redirect with same-cycle pop: head pc=0x10 handshaking while redirect to 0x40 ->
//    0x10 is consumed once, next out_pc=0x40.
//  5 Latency sweep: ROM_LATENCY=3, DEPTH=8 -> first out_valid at cycle 4, then sustained 1/cycle.
//    With DEPTH=4 throughput caps at 4 per 5 cycles.
//  6 Wrap/reset: redirect_pc=0xFFFFFFFC -> out_pc sequence 0xFFFFFFFC, 0x0.
//    rstn=0 mid-stream for 1 cycle -> out_valid=0 the next cycle, restart from pc 0.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch queue bus bundle: ROM read port plus the decode-side valid/ready port.
// master = fetch queue side, slave = ROM/decode side.
interface fetch_queue_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               rom_en;
    logic [ADDR_W-1:0]  rom_addr;
    logic [INSTR_W-1:0] rom_data;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [INSTR_W-1:0] out_instr;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_data,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_data,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr
    );
endinterface

// File: rtl/fetch_queue.sv
// Prefetching fetch stage: issues sequential PCs to a pipelined ROM and buffers
// {pc, instr} in a DEPTH-entry FIFO for decode; redirect flushes and restarts.
// Ports: clk, rstn (sync, active low), redirect/redirect_pc, fq (master bus).
module fetch_queue #(
    parameter int ADDR_W      = 32,
    parameter int INSTR_W     = 32,
    parameter int ROM_LATENCY = 1,
    parameter int DEPTH       = 4,
    parameter int PC_STEP     = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_queue_if.master     fq
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(DEPTH + ROM_LATENCY + 1) + 1;

    logic [ADDR_W-1:0]      fetch_pc;
    logic [ROM_LATENCY-1:0] pipe_vld;
    logic [ADDR_W-1:0]      pipe_pc [ROM_LATENCY];

    logic [PW-1:0]          rd_ptr;
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          count;
    logic [ADDR_W-1:0]      mem_pc    [DEPTH];
    logic [INSTR_W-1:0]     mem_instr [DEPTH];

    logic [CW-1:0]          inflight_cnt;
    logic                   issue;
    logic                   push;
    logic                   pop;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < ROM_LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CW'(pipe_vld[i]);
        end
    end

    assign count = wr_ptr - rd_ptr;

    // Credit: every slot is reserved at issue time, so returns never overflow.
    assign issue = rstn && !redirect &&
                   ((CW'(count) + inflight_cnt) < CW'(DEPTH));

    assign push = pipe_vld[ROM_LATENCY-1];
    assign pop  = fq.out_valid && fq.out_ready;

    assign fq.rom_en    = issue;
    assign fq.rom_addr  = fetch_pc;
    assign fq.out_valid = (count != '0);
    assign fq.out_pc    = fq.out_valid ? mem_pc[rd_ptr[AW-1:0]] : '0;
    assign fq.out_instr = fq.out_valid ? mem_instr[rd_ptr[AW-1:0]] : '0;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            fetch_pc <= '0;
        end else if (redirect) begin
            fetch_pc <= redirect_pc;
        end else if (issue) begin
            fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn || redirect) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= issue;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_pc[0] <= fetch_pc;
        for (int i = 1; i < ROM_LATENCY; i++) begin
            pipe_pc[i] <= pipe_pc[i-1];
        end
    end

    // Redirect drops everything younger than a head popped in the same cycle.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect) begin
            rd_ptr <= wr_ptr;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && !redirect && push) begin
            mem_pc[wr_ptr[AW-1:0]]    <= pipe_pc[ROM_LATENCY-1];
            mem_instr[wr_ptr[AW-1:0]] <= fq.rom_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn && !redirect) begin
            assert (!(push && count == PW'(DEPTH)));
        end
    end
endmodule
